// File: rtl/apb_irq_sleep_ctrl.sv
// apb_irq_sleep_ctrl
//   APB interrupt/event controller with an integrated core sleep sequencer.
//   Each line has edge/level capture, a mask, software set/clear and takes
//   part in a lowest-index-first ID encoder. A four-state FSM stops core
//   fetch, gates the core clock while asleep and, on wake-up, re-enables
//   fetch after WAKE_CYCLES clock-running cycles.
//
// Ports
//   HCLK, HRESET               clock, synchronous active-high reset
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE, PRDATA/PREADY/PSLVERR   APB slave
//   irq_i                      interrupt sources (synchronous to HCLK)
//   irq_o, irq_valid_o         pending & mask, and its OR-reduction
//   core_busy_i                core has not yet drained
//   fetch_en_o, clk_gate_core_o  core fetch enable / clock enable

// Per-line capture and pending state.
module apb_irq_line (
  input  logic HCLK,
  input  logic HRESET,
  input  logic irq,
  input  logic edge_mode,
  input  logic sw_set,
  input  logic sw_clr,
  output logic pend
);
  logic irq_q;
  logic cap;

  // Edge mode: rising edge only. Level mode: every cycle the source is high.
  assign cap = edge_mode ? (irq & ~irq_q) : irq;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_q <= irq;
      // Hardware capture beats CLEAR, which beats SET.
      if (cap)         pend <= 1'b1;
      else if (sw_clr) pend <= 1'b0;
      else if (sw_set) pend <= 1'b1;
    end
  end
endmodule

module apb_irq_sleep_ctrl #(
  parameter int NUM_IRQ        = 32,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int WAKE_CYCLES    = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_IRQ-1:0]        irq_i,
  output logic [NUM_IRQ-1:0]        irq_o,
  output logic                      irq_valid_o,
  input  logic                      core_busy_i,
  output logic                      fetch_en_o,
  output logic                      clk_gate_core_o
);
  localparam logic [2:0] A_MASK  = 3'd0;
  localparam logic [2:0] A_PEND  = 3'd1;
  localparam logic [2:0] A_SET   = 3'd2;
  localparam logic [2:0] A_CLR   = 3'd3;
  localparam logic [2:0] A_MODE  = 3'd4;
  localparam logic [2:0] A_ID    = 3'd5;
  localparam logic [2:0] A_SLEEP = 3'd6;
  localparam logic [2:0] A_STAT  = 3'd7;

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_REQ   = 2'b01,
    S_SLEEP = 2'b10,
    S_WAKE  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [NUM_IRQ-1:0] mask_q, mode_q, pend;
  logic [NUM_IRQ-1:0] sw_set, sw_clr;
  logic [7:0]         cnt_q;
  logic               aborted_q;
  logic [2:0]         idx;
  logic               unmapped, acc, wr, rd, ro_wr;
  logic [4:0]         id_idx;
  logic               unused_addr;

  assign unused_addr = ^PADDR[1:0];

  // Anything at offset 0x20 or above belongs to no register.
  generate
    if (APB_ADDR_WIDTH > 5) begin : g_hi
      assign unmapped = |PADDR[APB_ADDR_WIDTH-1:5];
    end else begin : g_nohi
      assign unmapped = 1'b0;
    end
  endgenerate

  assign idx    = PADDR[4:2];
  assign acc    = PSEL & PENABLE;
  assign ro_wr  = (idx == A_PEND) | (idx == A_ID) | (idx == A_STAT);
  // Erroring accesses must have no side effects, so they are excluded here.
  assign wr     = acc & PWRITE & ~unmapped & ~ro_wr;
  assign rd     = acc & ~PWRITE & ~unmapped;

  assign PREADY  = 1'b1;
  assign PSLVERR = acc & (unmapped | (PWRITE & ro_wr));

  assign sw_set = (wr && idx == A_SET) ? PWDATA[NUM_IRQ-1:0] : '0;
  assign sw_clr = (wr && idx == A_CLR) ? PWDATA[NUM_IRQ-1:0] : '0;

  // Per-line capture, one instance per interrupt line.
  apb_irq_line u_line [NUM_IRQ-1:0] (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .irq       (irq_i),
    .edge_mode (mode_q),
    .sw_set    (sw_set),
    .sw_clr    (sw_clr),
    .pend      (pend)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      mask_q <= '0;
      mode_q <= '0;
    end else if (wr) begin
      if (idx == A_MASK) mask_q <= PWDATA[NUM_IRQ-1:0];
      if (idx == A_MODE) mode_q <= PWDATA[NUM_IRQ-1:0];
    end
  end

  assign irq_o       = pend & mask_q;
  assign irq_valid_o = |irq_o;

  // Lowest active index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    id_idx = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_o[i]) id_idx = 5'(i);
    end
  end

  always_comb begin
    PRDATA = 32'h0;
    if (PSEL && !PWRITE && !unmapped) begin
      case (idx)
        A_MASK:  PRDATA = 32'(mask_q);
        A_PEND:  PRDATA = 32'(pend);
        A_MODE:  PRDATA = 32'(mode_q);
        A_ID:    PRDATA = irq_valid_o ? {1'b1, 26'h0, id_idx} : 32'h0;
        A_STAT:  PRDATA = {29'h0, aborted_q, state_q};
        default: PRDATA = 32'h0;
      endcase
    end
  end

  // Sleep FSM: state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // Sleep FSM: next state. A pending interrupt aborts a request even if the
  // core drains in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (wr && idx == A_SLEEP && PWDATA[0]) state_d = S_REQ;
      S_REQ:   if (irq_valid_o)       state_d = S_RUN;
               else if (!core_busy_i) state_d = S_SLEEP;
      S_SLEEP: if (irq_valid_o)       state_d = S_WAKE;
      S_WAKE:  if (cnt_q == 8'd0)     state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Sleep FSM: outputs.
  always_comb begin
    fetch_en_o      = 1'b0;
    clk_gate_core_o = 1'b1;
    case (state_q)
      S_RUN:   fetch_en_o      = 1'b1;
      S_SLEEP: clk_gate_core_o = 1'b0;
      default: ;
    endcase
  end

  // Settle counter loads only on SLEEP->WAKE and saturates at 0.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt_q <= 8'd0;
    end else if (state_q == S_SLEEP && irq_valid_o) begin
      cnt_q <= 8'(WAKE_CYCLES - 1);
    end else if (state_q == S_WAKE && cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  // Abort flag: a new abort wins over a simultaneous clear-on-read.
  always_ff @(posedge HCLK) begin
    if (HRESET)                            aborted_q <= 1'b0;
    else if (state_q == S_REQ && irq_valid_o) aborted_q <= 1'b1;
    else if (rd && idx == A_STAT)          aborted_q <= 1'b0;
  end
endmodule

// File: tb/tb_apb_irq_sleep_ctrl.sv
module tb_apb_irq_sleep_ctrl;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] irq_i;
  logic [31:0] irq_o;
  logic        irq_valid_o;
  logic        core_busy_i;
  logic        fetch_en_o, clk_gate_core_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] rdat;
  logic        rerr, werr;

  always #5 HCLK = ~HCLK;

  apb_irq_sleep_ctrl #(.NUM_IRQ(32), .APB_ADDR_WIDTH(12), .WAKE_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_i(irq_i), .irq_o(irq_o),
    .irq_valid_o(irq_valid_o), .core_busy_i(core_busy_i),
    .fetch_en_o(fetch_en_o), .clk_gate_core_o(clk_gate_core_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #1 werr = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #1 rdat = PRDATA; rerr = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0;
    PENABLE = 1'b0; irq_i = '0; core_busy_i = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Reset state
    chk("rst_fetch_en", 32'(fetch_en_o), 32'h1);
    chk("rst_clk_gate", 32'(clk_gate_core_o), 32'h1);
    chk("rst_irq_o", irq_o, 32'h0);
    chk("rst_irq_valid", 32'(irq_valid_o), 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h1);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    for (int i = 0; i < 8; i++) begin
      apb_rd(12'(i * 4));
      chk($sformatf("rst_reg_%0d", i), rdat, 32'h0);
      chk($sformatf("rst_reg_err_%0d", i), 32'(rerr), 32'h0);
    end
    apb_rd(12'h020);
    chk("unmapped_err", 32'(rerr), 32'h1);
    chk("unmapped_data", rdat, 32'h0);

    // Edge capture on line 0
    apb_wr(12'h010, 32'h1);
    apb_wr(12'h000, 32'h1);
    @(posedge HCLK); #1 irq_i[0] = 1'b1;
    @(posedge HCLK); #1 irq_i[0] = 1'b0;
    chk("edge_irq_o", irq_o, 32'h1);
    repeat (2) @(posedge HCLK);
    #1 chk("edge_held", irq_o, 32'h1);
    apb_rd(12'h004);
    chk("edge_pend", rdat, 32'h1);
    apb_rd(12'h014);
    chk("edge_id", rdat, 32'h8000_0000);
    apb_wr(12'h00C, 32'h1);
    apb_rd(12'h004);
    chk("edge_clr", rdat, 32'h0);

    // Write to a read-only register errors and has no effect
    apb_wr(12'h004, 32'hFFFF_FFFF);
    chk("ro_wr_err", 32'(werr), 32'h1);
    apb_rd(12'h004);
    chk("ro_wr_noeffect", rdat, 32'h0);

    // Level line 3: CLEAR loses while source is high
    apb_wr(12'h000, 32'h8);
    #1 irq_i[3] = 1'b1;
    apb_wr(12'h00C, 32'h8);
    apb_rd(12'h004);
    chk("level_clr_held", rdat, 32'h8);
    chk("level_irq_valid", 32'(irq_valid_o), 32'h1);
    irq_i[3] = 1'b0;
    apb_wr(12'h00C, 32'h8);
    apb_rd(12'h004);
    chk("level_clr_done", rdat, 32'h0);

    // ID with multiple pending, mask selects bit 4
    apb_wr(12'h008, 32'h14);
    apb_wr(12'h000, 32'h10);
    apb_rd(12'h004);
    chk("id_pend", rdat, 32'h14);
    apb_rd(12'h014);
    chk("id_val", rdat, 32'h8000_0004);
    chk("id_irq_o", irq_o, 32'h10);

    // Edge capture and CLEAR on bit 0 in the same cycle: capture wins
    @(posedge HCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 12'h00C; PWDATA = 32'h1; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1; irq_i[0] = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; irq_i[0] = 1'b0;
    apb_rd(12'h004);
    chk("cap_vs_clr", rdat, 32'h15);
    apb_wr(12'h00C, 32'hFFFF_FFFF);
    apb_rd(12'h004);
    chk("clr_all", rdat, 32'h0);

    // Sleep with busy core, then wake
    apb_wr(12'h000, 32'h1);
    core_busy_i = 1'b1;
    apb_wr(12'h018, 32'h1);
    chk("req_fetch", 32'(fetch_en_o), 32'h0);
    chk("req_clk", 32'(clk_gate_core_o), 32'h1);
    apb_rd(12'h01C);
    chk("req_status", rdat, 32'h1);
    repeat (5) @(posedge HCLK);
    #1 chk("req_busy_hold", 32'(clk_gate_core_o), 32'h1);
    core_busy_i = 1'b0;
    @(posedge HCLK); #1;
    chk("sleep_clk", 32'(clk_gate_core_o), 32'h0);
    chk("sleep_fetch", 32'(fetch_en_o), 32'h0);
    irq_i[0] = 1'b1;
    @(posedge HCLK); #1;
    irq_i[0] = 1'b0;
    chk("sleep_irq_valid", 32'(irq_valid_o), 32'h1);
    chk("sleep_still", 32'(clk_gate_core_o), 32'h0);
    @(posedge HCLK); #1;
    chk("wake_clk", 32'(clk_gate_core_o), 32'h1);
    chk("wake_fetch_0", 32'(fetch_en_o), 32'h0);
    for (int k = 1; k < 4; k++) begin
      @(posedge HCLK); #1;
      chk($sformatf("wake_fetch_%0d", k), 32'(fetch_en_o), 32'h0);
    end
    @(posedge HCLK); #1;
    chk("run_fetch", 32'(fetch_en_o), 32'h1);
    apb_rd(12'h01C);
    chk("run_status", rdat, 32'h0);

    // Sleep request aborted by an already-valid interrupt
    apb_wr(12'h018, 32'h1);
    chk("abort_req", 32'(fetch_en_o), 32'h0);
    @(posedge HCLK); #1;
    chk("abort_run", 32'(fetch_en_o), 32'h1);
    apb_rd(12'h01C);
    chk("abort_flag", rdat, 32'h4);
    apb_rd(12'h01C);
    chk("abort_flag_clr", rdat, 32'h0);

    // Reset while asleep
    apb_wr(12'h00C, 32'h1);
    apb_wr(12'h018, 32'h1);
    @(posedge HCLK); #1;
    chk("rs_sleep", 32'(clk_gate_core_o), 32'h0);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    chk("rs_fetch", 32'(fetch_en_o), 32'h1);
    chk("rs_clk", 32'(clk_gate_core_o), 32'h1);
    HRESET = 1'b0;
    apb_rd(12'h000);
    chk("rs_mask", rdat, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_irq_sleep_ctrl.md
# apb_irq_sleep_ctrl

Parametrised APB interrupt/event controller with an integrated core sleep sequencer, the successor to the fixed 32-line interrupt/event/sleep unit. It sits on the peripheral APB bus beside the core. Per line it provides configurable edge/level capture, masking, software set/clear and a priority-encoded ID register. A wake-up FSM gates the core clock and releases fetch enable after a programmable settle delay.

## Interface
- NUM_IRQ, 32: number of interrupt lines, 1..32; register bits above NUM_IRQ-1 read 0 and ignore writes.
- APB_ADDR_WIDTH, 12: APB address width.
- WAKE_CYCLES, 4: core-clock-enabled cycles in WAKE before fetch enable re-asserts, 1..255.
- HCLK  in  1  single clock for all logic.
- HRESET  in  1  synchronous, active-high reset.
- PADDR  in  APB_ADDR_WIDTH  APB address; only PADDR[4:2] decoded.
- PWDATA  in  32  write data.
- PWRITE, PSEL, PENABLE  in  1 each  APB control.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1 (zero wait states).
- PSLVERR  out  1  error response on an unmapped access.
- irq_i  in  NUM_IRQ  interrupt sources, synchronous to HCLK.
- irq_o  out  NUM_IRQ  pending & mask.
- irq_valid_o  out  1  |irq_o.
- core_busy_i  in  1  core still executing.
- fetch_en_o  out  1  core fetch enable.
- clk_gate_core_o  out  1  core clock enable, 1 = clock running.

## Operation
- An APB access takes effect when PSEL & PENABLE. Writes happen at the end of the access phase. Reads are combinational from the current registers.
- Register map:
  - 0x00 MASK RW, reset 0.
  - 0x04 PENDING RO.
  - 0x08 SET W1S into pending.
  - 0x0C CLEAR W1C from pending.
  - 0x10 MODE RW, bit = 1 selects edge capture, reset 0 (level).
  - 0x14 ID RO: bit31 = valid, bits[4:0] = lowest index of pending & mask, 0 when not valid.
  - 0x18 SLEEP_CTRL: write bit0 = 1 requests sleep; reads 0.
  - 0x1C STATUS RO: bits[1:0] = FSM state encoding, bit2 = aborted flag (cleared on read).
- Offsets 0x20 and above within the slave: PSLVERR = 1, PRDATA = 0, no side effects. Writes to RO registers: PSLVERR = 1.
- Capture:
  - Edge mode sets pending on irq_i & ~irq_q, where irq_q is irq_i registered.
  - Level mode sets pending in every cycle irq_i is high.
- Set/clear priority per bit: hardware capture > CLEAR > SET. A CLEAR while a level source is still high leaves the bit set.
- Sleep FSM states:
  - RUN (00): fetch_en_o = 1, clk_gate_core_o = 1. SLEEP_CTRL write with bit0 = 1 → REQ.
  - REQ (01): fetch_en_o = 0, clock running. If irq_valid_o → RUN and set the aborted flag. Otherwise, if ~core_busy_i → SLEEP.
  - SLEEP (10): clk_gate_core_o = 0, fetch_en_o = 0. If irq_valid_o → WAKE and load the counter with WAKE_CYCLES-1.
  - WAKE (11): clk_gate_core_o = 1, fetch_en_o = 0. Counter decrements each cycle; at 0 → RUN.
- Abort rule: irq_valid_o wins over ~core_busy_i in the same cycle.
- A SLEEP_CTRL write outside RUN is ignored (no error).
- The controller's own APB accesses remain functional in every state, since HCLK is never gated by this block.

## Timing
- Reset (HRESET = 1 at a rising HCLK edge): MASK, PENDING, MODE, irq_q and the aborted flag = 0; FSM = RUN; counter = 0.
- Outputs after reset: irq_o = 0, irq_valid_o = 0, fetch_en_o = 1, clk_gate_core_o = 1, PRDATA = 0, PSLVERR = 0, PREADY = 1.
- Reset mid-sleep returns to RUN on the next edge, with no WAKE delay.
- irq_i first sampled high at edge N → pending and irq_o high after edge N (visible in cycle N+1). Edge and level modes have the same latency.
- A SET/CLEAR write completing at edge N → PENDING updated after edge N.
- MASK changes affect irq_o combinationally from the registered MASK, i.e. the cycle after the write edge.
- FSM outputs are combinational decodes of the registered state.
- Interrupt in SLEEP at cycle N → WAKE after edge N+1 → fetch_en_o = 1 exactly WAKE_CYCLES cycles later.
- No wrap-around: the counter only loads in SLEEP and stops at 0.

## Test plan
- Reset, then read all registers → 0x0 except ID = 0x0000_0000; fetch_en_o = 1; read 0x20 → PSLVERR = 1.
- MODE = 0x1, MASK = 0x1, pulse irq_i[0] for 1 cycle → PENDING = 0x1 held; ID = 0x8000_0000; CLEAR 0x1 → PENDING = 0.
- Level line 3 held high, MASK = 0x8: write CLEAR 0x8 → PENDING still 0x8. Drop irq_i[3], then CLEAR → 0x0.
- PENDING = 0x14 with MASK = 0x10 → ID = 0x8000_0004. Edge capture and CLEAR on the same bit in the same cycle → bit stays 1.
- Sleep request with core_busy_i = 1 for 5 cycles, then 0 → SLEEP, clk_gate_core_o = 0. Raise masked-in irq → WAKE for WAKE_CYCLES = 4 cycles, then RUN, fetch_en_o = 1.
- Sleep request with irq_valid_o already 1 → REQ → RUN, STATUS bit2 = 1, then reads 0 on the second read. Assert HRESET during SLEEP → RUN next cycle.
